// File: rtl/sent_crc_checker.sv
// Bit-serial CRC checker for the SENT receive path.
// Shifts one data bit per cycle, optional zero-nibble augmentation.
module sent_crc_checker #(
    parameter int               CRC_W   = 4,
    parameter logic [CRC_W-1:0] POLY    = 'hD,
    parameter logic [CRC_W-1:0] SEED    = 'h5,
    parameter int               MAX_NIB = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_aug_en,
    input  logic [3:0]       i_din,
    input  logic             i_din_valid,
    input  logic             i_din_last,
    input  logic [CRC_W-1:0] i_crc_rx,
    output logic             o_din_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [CRC_W-1:0] o_crc_out,
    output logic             o_crc_ok,
    output logic             o_err_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SHIFT,
        S_AUG,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_crc_rx;
    logic [3:0]       r_cnt;
    logic [3:0]       r_nib;
    logic [1:0]       r_bit;
    logic             r_last;
    logic             r_aug;
    logic             r_err;
    logic             w_hs;
    logic             w_ready_nx;
    logic             w_busy_nx;
    logic             w_done_nx;

    function automatic logic [CRC_W-1:0] f_step(
        input logic [CRC_W-1:0] c,
        input logic             b
    );
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // o_din_ready is high exactly while in ACCEPT
    assign w_hs = o_din_ready & i_din_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = S_ACCEPT;
        end else begin
            unique case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_ACCEPT: if (w_hs) w_next = S_SHIFT;
                S_SHIFT: begin
                    if (r_bit == 2'd3) begin
                        if (!r_last)    w_next = S_ACCEPT;
                        else if (r_aug) w_next = S_AUG;
                        else            w_next = S_DONE;
                    end
                end
                S_AUG:    if (r_bit == 2'd3) w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready_nx = (w_next == S_ACCEPT);
        w_busy_nx  = (w_next != S_IDLE);
        w_done_nx  = (r_state == S_DONE) && !i_start;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_din_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_crc_out   <= '0;
            o_crc_ok    <= 1'b0;
            o_err_len   <= 1'b0;
        end else begin
            o_din_ready <= w_ready_nx;
            o_busy      <= w_busy_nx;
            o_done      <= w_done_nx;
            if (i_start) begin
                o_crc_out <= '0;
                o_crc_ok  <= 1'b0;
                o_err_len <= 1'b0;
            end else if (w_done_nx) begin
                o_crc_out <= r_crc;
                o_crc_ok  <= (r_crc == r_crc_rx) && !r_err;
                o_err_len <= r_err;
            end
        end
    end

    // Datapath: nibble latch, bit shifter, length tracking
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_crc    <= SEED;
            r_crc_rx <= '0;
            r_cnt    <= '0;
            r_nib    <= '0;
            r_bit    <= '0;
            r_last   <= 1'b0;
            r_aug    <= 1'b0;
            r_err    <= 1'b0;
        end else if (i_start) begin
            r_crc  <= SEED;
            r_cnt  <= '0;
            r_bit  <= '0;
            r_last <= 1'b0;
            r_aug  <= i_aug_en;
            r_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_ACCEPT: begin
                    if (w_hs) begin
                        r_nib  <= i_din;
                        r_bit  <= '0;
                        r_last <= i_din_last;
                        if (i_din_last)
                            r_crc_rx <= i_crc_rx;
                        if (r_cnt == 4'(MAX_NIB))
                            r_err <= 1'b1;
                        if (r_cnt != 4'hF)
                            r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SHIFT: begin
                    r_crc <= f_step(r_crc, r_nib[3]);
                    r_nib <= {r_nib[2:0], 1'b0};
                    r_bit <= r_bit + 2'd1;
                end
                S_AUG: begin
                    r_crc <= f_step(r_crc, 1'b0);
                    r_bit <= r_bit + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sent_crc_checker.sv
// Scoreboard bench for sent_crc_checker: default instance plus a
// MAX_NIB=2 instance driven with the same stimulus.
module tb_sent_crc_checker;

    typedef struct {
        logic [3:0] crc;
        logic       ok;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       aug_en = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_last = 1'b0;
    logic [3:0] crc_rx = '0;

    logic       rdy1, busy1, done1, ok1, err1;
    logic [3:0] crc1;
    logic       rdy2, busy2, done2, ok2, err2;
    logic [3:0] crc2;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];

    logic [3:0] m_crc;
    int         m_cnt;
    logic       m_err1, m_err2, m_aug;
    int         last_hs;

    sent_crc_checker u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_aug_en(aug_en),
        .i_din(din), .i_din_valid(din_valid), .i_din_last(din_last),
        .i_crc_rx(crc_rx), .o_din_ready(rdy1), .o_busy(busy1),
        .o_done(done1), .o_crc_out(crc1), .o_crc_ok(ok1), .o_err_len(err1)
    );

    sent_crc_checker #(.MAX_NIB(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_aug_en(aug_en),
        .i_din(din), .i_din_valid(din_valid), .i_din_last(din_last),
        .i_crc_rx(crc_rx), .o_din_ready(rdy2), .o_busy(busy2),
        .o_done(done2), .o_crc_out(crc2), .o_crc_ok(ok2), .o_err_len(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] crc_nib(input logic [3:0] c,
                                           input logic [3:0] n);
        logic [3:0] r;
        r = c;
        for (int i = 3; i >= 0; i--)
            r = {r[2:0], 1'b0} ^ ((r[3] ^ n[i]) ? 4'hD : 4'h0);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_done1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("crc_out1", crc1, e.crc);
                    chk("crc_ok1", ok1, e.ok);
                    chk("err_len1", err1, e.err);
                    chk("done_cyc1", cyc, e.cyc);
                end
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_done2", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("crc_out2", crc2, e.crc);
                    chk("crc_ok2", ok2, e.ok);
                    chk("err_len2", err2, e.err);
                end
            end
        end
    end

    task automatic do_start(input logic aug);
        start  = 1'b1;
        aug_en = aug;
        @(posedge clk);
        #1;
        start  = 1'b0;
        m_crc  = 4'h5;
        m_cnt  = 0;
        m_err1 = 1'b0;
        m_err2 = 1'b0;
        m_aug  = aug;
        chk("start_busy", busy1, 1);
        chk("start_ready", rdy1, 1);
        chk("start_clr_crc", crc1, 0);
    endtask

    task automatic send_nib(input logic [3:0] n, input logic last,
                            input logic [3:0] rx, input logic keep);
        bit   got;
        int   h;
        exp_t e;
        din       = n;
        din_valid = 1'b1;
        din_last  = last;
        crc_rx    = rx;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("hs_timeout", 0, 1);
            din_valid = 1'b0;
            return;
        end
        h = cyc;
        @(posedge clk);
        #1;
        last_hs = h;
        if (m_cnt == 8) m_err1 = 1'b1;
        if (m_cnt == 2) m_err2 = 1'b1;
        if (m_cnt != 15) m_cnt++;
        m_crc = crc_nib(m_crc, n);
        if (last) begin
            if (m_aug) m_crc = crc_nib(m_crc, 4'h0);
            e.crc = m_crc;
            e.cyc = h + (m_aug ? 10 : 6);
            e.ok  = (m_crc == rx) && !m_err1;
            e.err = m_err1;
            q1.push_back(e);
            e.ok  = (m_crc == rx) && !m_err2;
            e.err = m_err2;
            q2.push_back(e);
        end
        if (!keep) begin
            din_valid = 1'b0;
            din_last  = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int         h1;
        int         len;
        logic       a;
        logic [3:0] c;
        logic [3:0] nibs[4];

        #12;
        chk("rst_ready", rdy1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_crc", crc1, 0);
        chk("rst_ok", ok1, 0);
        chk("rst_err", err1, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_start(1'b0);
        send_nib(4'h0, 1'b1, 4'h3, 1'b0);
        settle();
        chk("tp1_crc_held", crc1, 4'h3);
        chk("tp1_ok_held", ok1, 1);
        chk("tp1_idle", busy1, 0);

        do_start(1'b0);
        send_nib(4'hF, 1'b1, 4'h3, 1'b0);
        settle();
        chk("tp2_crc_held", crc1, 4'h6);

        do_start(1'b1);
        send_nib(4'h0, 1'b1, 4'hA, 1'b0);
        settle();
        chk("tp3_crc_held", crc1, 4'hA);

        do_start(1'b0);
        send_nib(4'h0, 1'b0, 4'h0, 1'b1);
        h1 = last_hs;
        send_nib(4'hF, 1'b1, 4'hF, 1'b0);
        chk("tp4_hs_gap", last_hs - h1, 5);
        settle();
        chk("tp4_crc_held", crc1, 4'hF);

        do_start(1'b0);
        send_nib(4'h1, 1'b0, 4'h0, 1'b0);
        send_nib(4'h2, 1'b0, 4'h0, 1'b0);
        send_nib(4'h3, 1'b1, crc_nib(m_crc, 4'h3), 1'b0);
        settle();
        chk("tp5_err2_held", err2, 1);
        chk("tp5_ok1_held", ok1, 1);

        do_start(1'b0);
        send_nib(4'h5, 1'b0, 4'h0, 1'b0);
        do_start(1'b0);
        send_nib(4'h0, 1'b1, 4'h3, 1'b0);
        settle();
        chk("tp6_crc_held", crc1, 4'h3);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 4);
            a   = 1'($urandom_range(0, 1));
            c   = 4'h5;
            for (int i = 0; i < len; i++) begin
                nibs[i] = 4'($urandom);
                c = crc_nib(c, nibs[i]);
            end
            if (a) c = crc_nib(c, 4'h0);
            if ($urandom_range(0, 1) == 0) c = 4'($urandom);
            do_start(a);
            for (int i = 0; i < len; i++)
                send_nib(nibs[i], i == len - 1, c, 1'b0);
            settle();
        end

        do_start(1'b0);
        send_nib(4'h7, 1'b0, 4'h0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", rdy1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_crc", crc1, 0);
        chk("mid_rst_ok", ok1, 0);
        chk("mid_rst_err", err1, 0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sent_crc_checker.md
# sent_crc_checker

Parametrised, bit-serial CRC engine for the SENT receive path. It accepts a frame of data nibbles over a valid/ready handshake and computes the CRC, with an optional zero-nibble augmentation for the SAE J2716 recommended mode. It compares the result against the received CRC nibble and reports pass/fail with a one-cycle done pulse. It sits between the nibble decoder and the frame buffer and replaces the fixed 4-bit, one-nibble-per-cycle CRC update.

## Interface
- CRC_W, 4: CRC width in bits (4 for fast channel, 6 for enhanced serial).
- POLY, 4'hD: generator polynomial without the x^CRC_W term (default x^4+x^3+x^2+1).
- SEED, 4'h5: value loaded into the CRC register on start.
- MAX_NIB, 8: maximum number of data nibbles per frame (1..15).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  frame start pulse; loads SEED, latches aug_en, clears status.
- aug_en  input  1  1 = append one zero nibble after the last data nibble (recommended mode).
- din  input  4  data nibble, processed MSB first.
- din_valid  input  1  nibble valid.
- din_last  input  1  marks the final data nibble; qualified by din_valid.
- crc_rx  input  CRC_W  received CRC; sampled on the din_last handshake.
- din_ready  output  1  engine can accept a nibble.
- busy  output  1  frame in progress (any state except IDLE).
- done  output  1  one-cycle pulse; result valid.
- crc_out  output  CRC_W  computed CRC; held until next start.
- crc_ok  output  1  crc_out == crc_rx and no length error; held until next start.
- err_len  output  1  more than MAX_NIB nibbles received; held until next start.

## Operation
- States: IDLE, ACCEPT, SHIFT, AUG, DONE.
- IDLE: din_ready=0. On start, go to ACCEPT.
- ACCEPT: din_ready=1. A handshake (din_valid & din_ready) latches din, increments the nibble count and goes to SHIFT. If din_last is also set, crc_rx and the last flag are latched.
- SHIFT: 4 cycles, one bit per cycle, MSB first. Per bit: fb = crc[CRC_W-1] ^ bit; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - After bit 0, if not last: go to ACCEPT.
  - If last and aug_en: go to AUG.
  - Otherwise: go to DONE.
- AUG: 4 cycles shifting zero bits with the same update, then go to DONE.
- DONE: 1 cycle. done=1; crc_out, crc_ok and err_len are updated. Then go to IDLE.
- Length rule: the nibble count is 4 bits and saturates. A handshake when count == MAX_NIB sets err_len. The nibble is still shifted. crc_ok is forced to 0 for that frame.
- start in any state aborts the current frame:
  - reloads SEED, clears count, err_len and crc_ok;
  - goes to ACCEPT next cycle;
  - no done pulse for the aborted frame;
  - start has priority over a simultaneous handshake, and that nibble is dropped.
- din_valid while din_ready=0 is ignored. The source must hold the nibble until the handshake.
- For CRC_W < 4 the configuration is unsupported. The update rule above is width-generic for CRC_W ≥ 4.

## Timing
- Reset (async): state=IDLE, crc register=SEED, nibble count=0, din_ready=0, busy=0, done=0, crc_out=0, crc_ok=0, err_len=0.
- All outputs are registered.
- start sampled on edge t: busy=1 and din_ready=1 after edge t.
- Handshake on edge k: din_ready=0 after k. Bits are shifted on edges k+1..k+4. If not last, din_ready=1 after k+4, so the next handshake is earliest at edge k+5.
- Throughput: one nibble per 5 cycles.
- Last-nibble handshake on edge k: done is high for the cycle after edge k+5 (no augmentation) or k+9 (augmentation). crc_out and crc_ok are valid from that cycle.
- busy drops after the DONE cycle.
- Reset asserted mid-frame: the frame is lost, with no done pulse.

## Test plan
- Default params, start, aug_en=0, single nibble 0x0 with din_last, crc_rx=0x3 -> done 5 cycles after the handshake, crc_out=0x3, crc_ok=1.
- aug_en=0, single nibble 0xF, crc_rx=0x3 -> crc_out=0x6, crc_ok=0, err_len=0.
- aug_en=1, single nibble 0x0, crc_rx=0xA -> done 9 cycles after the handshake, crc_out=0xA, crc_ok=1.
- aug_en=0, nibbles 0x0 then 0xF(last), crc_rx=0xF, din_valid held high throughout -> handshakes exactly 5 cycles apart, crc_out=0xF, crc_ok=1.
- MAX_NIB=2, three nibbles, last one flagged, crc_rx equal to the true CRC -> err_len=1, crc_ok=0, a single done pulse.
- start asserted in the SHIFT state of a frame, then frame 0x0(last) with crc_rx=0x3 -> no done for the aborted frame; new frame gives crc_out=0x3, crc_ok=1. Async reset mid-frame -> all outputs at reset values immediately.
